// File: rtl/mem_port_arb.sv
// Arbitrates IF fetches and MEM data accesses onto one memory port: grants in IDLE, holds CSN low WAIT_CYC cycles, pulses RVALID.
// Tie-break is fixed D-priority by default; define MEM_ARB_RR_EN for round-robin on ties.
module mem_port_arb #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int WAIT_CYC = 1
) (
  input  logic                CLK,
  input  logic                RSTn,
  input  logic                I_REQ,
  input  logic [ADDR_W-1:0]   I_ADDR,
  output logic                I_GNT,
  output logic                I_RVALID,
  output logic [DATA_W-1:0]   I_RDATA,
  input  logic                D_REQ,
  input  logic                D_WE,
  input  logic [DATA_W/8-1:0] D_BE,
  input  logic [ADDR_W-1:0]   D_ADDR,
  input  logic [DATA_W-1:0]   D_WDATA,
  output logic                D_GNT,
  output logic                D_RVALID,
  output logic [DATA_W-1:0]   D_RDATA,
  output logic                ARB_BUSY,
  output logic                MEM_CSN,
  output logic                MEM_WEN,
  output logic [DATA_W/8-1:0] MEM_BE,
  output logic [ADDR_W-1:0]   MEM_ADDR,
  output logic [DATA_W-1:0]   MEM_DO,
  input  logic [DATA_W-1:0]   MEM_DI
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYC - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;  // 1 = data side owns the access
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                i_win, d_win;
  logic                tie_pick_d;

`ifdef MEM_ARB_RR_EN
  logic last_d_q, last_d_d;

  assign tie_pick_d = ~last_d_q;

  always_comb begin
    last_d_d = last_d_q;
    if (i_win || d_win) last_d_d = d_win;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) last_d_q <= 1'b1;
    else       last_d_q <= last_d_d;
  end
`else
  assign tie_pick_d = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    we_d      = we_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_win     = 1'b0;
    d_win     = 1'b0;
    case (state_q)
      IDLE: begin
        if (I_REQ && D_REQ) begin
          d_win = tie_pick_d;
          i_win = ~tie_pick_d;
        end else begin
          i_win = I_REQ;
          d_win = D_REQ;
        end
        if (i_win || d_win) begin
          state_d = ACCESS;
          owner_d = d_win;
          cnt_d   = CNT_INIT;
          if (d_win) begin
            addr_d  = D_ADDR;
            we_d    = D_WE;
            be_d    = D_BE;
            wdata_d = D_WDATA;
          end else begin
            addr_d  = I_ADDR;
            we_d    = 1'b0;
          end
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          if (!we_q) begin
            if (owner_q) d_rdata_d = MEM_DI;
            else         i_rdata_d = MEM_DI;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      be_q      <= '0;
      wdata_q   <= '0;
      cnt_q     <= 4'd0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign I_GNT    = i_win;
  assign D_GNT    = d_win;
  assign I_RVALID = (state_q == RESP) && !owner_q;
  assign D_RVALID = (state_q == RESP) && owner_q;
  assign I_RDATA  = i_rdata_q;
  assign D_RDATA  = d_rdata_q;
  assign ARB_BUSY = (state_q != IDLE);
  assign MEM_CSN  = (state_q != ACCESS);
  assign MEM_WEN  = !((state_q == ACCESS) && we_q);
  // Loads always read the full word regardless of the latched byte enables.
  assign MEM_BE   = (state_q != ACCESS) ? '0 : (we_q ? be_q : '1);
  assign MEM_ADDR = addr_q;
  assign MEM_DO   = wdata_q;

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed bench for mem_port_arb: one WAIT_CYC=1 instance and one WAIT_CYC=3 instance.
module tb_mem_port_arb;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        I_REQ = 1'b0;
  logic [11:0] I_ADDR = '0;
  logic        D_REQ = 1'b0;
  logic        D_WE = 1'b0;
  logic [3:0]  D_BE = '0;
  logic [11:0] D_ADDR = '0;
  logic [31:0] D_WDATA = '0;
  logic [31:0] MEM_DI = '0;

  logic        I_GNT, I_RVALID, D_GNT, D_RVALID, ARB_BUSY, MEM_CSN, MEM_WEN;
  logic [31:0] I_RDATA, D_RDATA, MEM_DO;
  logic [3:0]  MEM_BE;
  logic [11:0] MEM_ADDR;

  logic        w3_d_req = 1'b0;
  logic [31:0] w3_mem_di = '0;
  logic        w3_i_gnt, w3_i_rvalid, w3_d_gnt, w3_d_rvalid, w3_busy, w3_csn, w3_wen;
  logic [31:0] w3_i_rdata, w3_d_rdata, w3_mem_do;
  logic [3:0]  w3_mem_be;
  logic [11:0] w3_mem_addr;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  mem_port_arb #(.ADDR_W(12), .DATA_W(32), .WAIT_CYC(1)) u_dut (
    .CLK(CLK), .RSTn(RSTn),
    .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_GNT(I_GNT), .I_RVALID(I_RVALID), .I_RDATA(I_RDATA),
    .D_REQ(D_REQ), .D_WE(D_WE), .D_BE(D_BE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
    .D_GNT(D_GNT), .D_RVALID(D_RVALID), .D_RDATA(D_RDATA), .ARB_BUSY(ARB_BUSY),
    .MEM_CSN(MEM_CSN), .MEM_WEN(MEM_WEN), .MEM_BE(MEM_BE), .MEM_ADDR(MEM_ADDR),
    .MEM_DO(MEM_DO), .MEM_DI(MEM_DI)
  );

  mem_port_arb #(.ADDR_W(12), .DATA_W(32), .WAIT_CYC(3)) u_dut3 (
    .CLK(CLK), .RSTn(RSTn),
    .I_REQ(1'b0), .I_ADDR(12'h000), .I_GNT(w3_i_gnt), .I_RVALID(w3_i_rvalid), .I_RDATA(w3_i_rdata),
    .D_REQ(w3_d_req), .D_WE(D_WE), .D_BE(D_BE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
    .D_GNT(w3_d_gnt), .D_RVALID(w3_d_rvalid), .D_RDATA(w3_d_rdata), .ARB_BUSY(w3_busy),
    .MEM_CSN(w3_csn), .MEM_WEN(w3_wen), .MEM_BE(w3_mem_be), .MEM_ADDR(w3_mem_addr),
    .MEM_DO(w3_mem_do), .MEM_DI(w3_mem_di)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // Tie expectations: first and second winners (1 = data side).
`ifdef MEM_ARB_RR_EN
  localparam logic TIE1_D = 1'b0;
  localparam logic TIE2_D = 1'b1;
`else
  localparam logic TIE1_D = 1'b1;
  localparam logic TIE2_D = 1'b1;
`endif

  initial begin
    logic w1, w2;
    w1 = TIE1_D;
    w2 = TIE2_D;

    // Reset values while RSTn is low
    cyc(); cyc();
    #1;
    check("rst_busy",   ARB_BUSY, 0);
    check("rst_csn",    MEM_CSN, 1);
    check("rst_wen",    MEM_WEN, 1);
    check("rst_be",     MEM_BE, 0);
    check("rst_addr",   MEM_ADDR, 0);
    check("rst_do",     MEM_DO, 0);
    check("rst_irdata", I_RDATA, 0);
    check("rst_drdata", D_RDATA, 0);
    check("rst_rvalid", {I_RVALID, D_RVALID}, 0);
    cyc();
    RSTn = 1'b1;

    // Instruction fetch, WAIT_CYC=1
    cyc();
    I_REQ = 1'b1; I_ADDR = 12'h010; MEM_DI = 32'h0050_0093;
    #1;
    check("if_gnt", {I_GNT, D_GNT}, 2'b10);
    cyc();
    I_REQ = 1'b0;
    #1;
    check("if_csn",  MEM_CSN, 0);
    check("if_wen",  MEM_WEN, 1);
    check("if_addr", MEM_ADDR, 12'h010);
    check("if_be",   MEM_BE, 4'hF);
    check("if_busy1", ARB_BUSY, 1);
    check("if_rv_early", I_RVALID, 0);
    cyc(); #1;
    check("if_rvalid", {I_RVALID, D_RVALID}, 2'b10);
    check("if_rdata",  I_RDATA, 32'h0050_0093);
    check("if_csn_resp", MEM_CSN, 1);
    cyc(); #1;
    check("if_busy3", ARB_BUSY, 0);
    check("if_rv_off", I_RVALID, 0);

    // Store
    D_REQ = 1'b1; D_WE = 1'b1; D_ADDR = 12'h100; D_BE = 4'hF; D_WDATA = 32'hDEAD_BEEF;
    #1;
    check("st_gnt", {I_GNT, D_GNT}, 2'b01);
    cyc();
    D_REQ = 1'b0; D_WDATA = 32'h0; D_WE = 1'b0;
    #1;
    check("st_wen",  MEM_WEN, 0);
    check("st_do",   MEM_DO, 32'hDEAD_BEEF);
    check("st_addr", MEM_ADDR, 12'h100);
    check("st_be",   MEM_BE, 4'hF);
    cyc(); #1;
    check("st_rvalid", {I_RVALID, D_RVALID}, 2'b01);
    check("st_rdata",  D_RDATA, 0);
    check("st_wen_off", MEM_WEN, 1);
    check("st_be_off",  MEM_BE, 0);
    check("st_do_hold", MEM_DO, 32'hDEAD_BEEF);
    cyc();

    // Two back-to-back ties (loads on both sides); losers keep requesting
    MEM_DI = 32'h0BAD_F00D;
    I_REQ = 1'b1; I_ADDR = 12'h030;
    D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = 12'h020;
    #1;
    check("tie1_gnt", {I_GNT, D_GNT}, {~w1, w1});
    cyc();
    if (w1) D_REQ = 1'b0; else I_REQ = 1'b0;
    #1;
    check("tie1_addr", MEM_ADDR, w1 ? 12'h020 : 12'h030);
    cyc(); #1;
    check("tie1_rvalid", {I_RVALID, D_RVALID}, {~w1, w1});
    cyc();
    I_REQ = 1'b1; D_REQ = 1'b1;
    #1;
    check("tie2_gnt", {I_GNT, D_GNT}, {~w2, w2});
    cyc();
    if (w2) D_REQ = 1'b0; else I_REQ = 1'b0;
    cyc(); cyc();
    #1;
    check("tie3_gnt", {I_GNT, D_GNT}, {w2, ~w2});
    cyc();
    I_REQ = 1'b0; D_REQ = 1'b0;
    cyc(); cyc();
    #1;
    check("tie_drdata", D_RDATA, 32'h0BAD_F00D);
    check("tie_busy", ARB_BUSY, 0);

    // WAIT_CYC=3 load with MEM_DI changing every cycle
    w3_d_req = 1'b1; D_WE = 1'b0; D_ADDR = 12'h055; w3_mem_di = 32'hA0;
    #1;
    check("w3_gnt", w3_d_gnt, 1);
    for (int k = 1; k <= 3; k++) begin
      cyc();
      w3_d_req = 1'b0; w3_mem_di = 32'hA0 + k;
      #1;
      check("w3_csn", w3_csn, 0);
      check("w3_rv_early", w3_d_rvalid, 0);
    end
    cyc();
    w3_mem_di = 32'hA4;
    #1;
    check("w3_rvalid", w3_d_rvalid, 1);
    check("w3_rdata",  w3_d_rdata, 32'hA3);
    check("w3_csn_off", w3_csn, 1);
    cyc(); #1;
    check("w3_rv_off", w3_d_rvalid, 0);
    check("w3_rdata_hold", w3_d_rdata, 32'hA3);

    // Reset during ACCESS
    I_REQ = 1'b1; I_ADDR = 12'h040; MEM_DI = 32'h1111_2222;
    #1;
    check("ra_gnt", I_GNT, 1);
    cyc();
    I_REQ = 1'b0;
    #1;
    check("ra_csn_pre", MEM_CSN, 0);
    RSTn = 1'b0;
    #1;
    check("ra_csn",    MEM_CSN, 1);
    check("ra_busy",   ARB_BUSY, 0);
    check("ra_addr",   MEM_ADDR, 0);
    check("ra_irdata", I_RDATA, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(); #1;
      check("ra_no_rvalid", {I_RVALID, D_RVALID}, 0);
    end
    RSTn = 1'b1;
    I_REQ = 1'b1; I_ADDR = 12'h050; MEM_DI = 32'h3333_4444;
    #1;
    check("ra_regnt", I_GNT, 1);
    cyc();
    I_REQ = 1'b0;
    #1;
    check("ra_re_addr", MEM_ADDR, 12'h050);
    cyc(); #1;
    check("ra_re_rvalid", I_RVALID, 1);
    check("ra_re_rdata",  I_RDATA, 32'h3333_4444);
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arb.md
# mem_port_arb

Two-requester arbiter and sequencer for the single shared memory port of the multicycle core. It accepts instruction-fetch requests (IF stage, IorD=0) and data requests (MEM stage, IorD=1). It grants one at a time, drives the memory control/address/data pins for a fixed access window, and returns read data with a one-cycle valid pulse. It sits between the control/datapath and the unified memory model, replacing the direct IorD address mux.

## Interface
Parameters:
- ADDR_W, 12, memory word-address width
- DATA_W, 32, data width; byte enables are DATA_W/8 bits wide
- WAIT_CYC, 1, number of cycles MEM_CSN is held low per access; legal range 1..15

Ports:
- Clocking: one clock; reset is asynchronous and active-low.
- CLK  in  1  clock, rising edge
- RSTn  in  1  asynchronous active-low reset
- I_REQ  in  1  fetch request; level, held until I_GNT
- I_ADDR  in  ADDR_W  fetch address
- I_GNT  out  1  fetch request accepted this cycle
- I_RVALID  out  1  one-cycle pulse; I_RDATA valid
- I_RDATA  out  DATA_W  fetched instruction
- D_REQ  in  1  data request; level, held until D_GNT
- D_WE  in  1  1 = store, 0 = load
- D_BE  in  DATA_W/8  store byte enables
- D_ADDR  in  ADDR_W  data address
- D_WDATA  in  DATA_W  store data
- D_GNT  out  1  data request accepted this cycle
- D_RVALID  out  1  one-cycle pulse; load data valid, or store complete
- D_RDATA  out  DATA_W  load data
- ARB_BUSY  out  1  state is not IDLE
- MEM_CSN  out  1  memory chip select, active low
- MEM_WEN  out  1  memory write enable, active low
- MEM_BE  out  DATA_W/8  memory byte enables
- MEM_ADDR  out  ADDR_W  memory address
- MEM_DO  out  DATA_W  memory write data
- MEM_DI  in  DATA_W  memory read data

## Operation
- **FSM states:** IDLE, ACCESS and RESP.
- **IDLE**
  - If any REQ is high, the winner's GNT is asserted combinationally in the same cycle.
  - On that edge the block latches the winner's ID, address, WE, BE and WDATA, loads wait counter = WAIT_CYC-1, and moves to ACCESS.
  - At most one GNT is high in any cycle.
- **ACCESS**
  - MEM_CSN=0 and MEM_ADDR/MEM_BE/MEM_DO come from the latched request.
  - MEM_WEN=0 only for a store. For a load, MEM_BE=all ones.
  - The counter decrements each cycle. In the cycle where counter==0:
    - for a load, MEM_DI is captured into the owner's RDATA register;
    - the FSM moves to RESP.
- **RESP:** the owner's RVALID=1 for exactly this cycle, then the FSM returns to IDLE. No grant is issued in RESP.
- **Outside ACCESS:**
  - MEM_CSN=1, MEM_WEN=1, MEM_BE=0.
  - MEM_ADDR and MEM_DO hold their last latched value.
- **Stores:** D_RVALID pulses as a completion acknowledgement. D_RDATA is unchanged.
- **RDATA:** I_RDATA and D_RDATA hold their value until the next completed load of the same requester.
- **Requester rules:**
  - Inputs must be stable while REQ=1 and GNT=0.
  - After GNT the requester may change inputs freely.
  - REQ still high in the cycle after GNT is a new request, evaluated in the next IDLE.
- **Tie-break** (both REQ high in IDLE): see Configuration.
- **Reset** (RSTn low, including mid-ACCESS or mid-RESP): the access is aborted immediately and no RVALID is issued.
  - State=IDLE, GNT/RVALID=0, ARB_BUSY=0.
  - MEM_CSN=1, MEM_WEN=1, MEM_BE=0, MEM_ADDR=0, MEM_DO=0.
  - I_RDATA=D_RDATA=0, round-robin pointer="last=D".

## Timing
- Request accepted in cycle n (GNT high) -> ACCESS in cycles n+1..n+WAIT_CYC -> RVALID in cycle n+WAIT_CYC+1 -> IDLE in n+WAIT_CYC+2.
- Minimum issue interval per access is WAIT_CYC+2 cycles. With WAIT_CYC=1: 3 cycles.
- GNT is combinational from REQ in IDLE only. All other outputs are registered or decoded from state.
- ARB_BUSY=1 in ACCESS and RESP.

## Configuration
- Macro MEM_ARB_RR_EN.
- **Defined:** round-robin on ties. The winner is the requester not granted last; the pointer updates on every grant. After reset the fetch side wins the first tie.
- **Undefined:** fixed priority. D wins every tie, so the in-flight instruction's memory stage always completes before the next fetch. The pointer logic is absent.
- With a single requester active, both builds behave identically.

## Test plan
- Reset, then I_REQ=1 with I_ADDR=0x010 and WAIT_CYC=1, MEM_DI=0x00500093 -> I_GNT high in cycle 0; MEM_CSN=0, MEM_WEN=1, MEM_ADDR=0x010 in cycle 1; I_RVALID=1 with I_RDATA=0x00500093 in cycle 2; ARB_BUSY=0 in cycle 3.
- Store with D_WE=1, D_ADDR=0x100, D_BE=4'b1111, D_WDATA=0xDEADBEEF -> MEM_WEN=0, MEM_DO=0xDEADBEEF for one cycle; D_RVALID pulses; D_RDATA unchanged.
- I_REQ and D_REQ raised in the same IDLE cycle, twice in a row:
  - with MEM_ARB_RR_EN undefined -> D, then D;
  - with it defined -> I, then D.
- WAIT_CYC=3, load with MEM_DI changing every cycle -> D_RDATA equals the MEM_DI value in the third ACCESS cycle; D_RVALID in cycle n+4.
- RSTn pulsed low during ACCESS -> MEM_CSN=1 immediately, no RVALID ever; after release, a new I_REQ is granted in the first IDLE cycle.
